// File: rtl/mic_frontend_pkg.sv
// Shared constants, FSM state type and saturation helper for the microphone
// conditioning path.
package constants;

  localparam int SYNTH_WIDTH    = 24;
  localparam int MIC_DC_SHIFT   = 10;
  localparam int MIC_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILT = 2'd1,
    S_GAIN = 2'd2,
    S_PUSH = 2'd3
  } mic_fe_state_t;

  // Clamp a sign-extended value to the signed range of a w-bit word.
  // Callers truncate the result back to w bits.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                      input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mic_frontend_sync_fifo.sv
// First-word-fall-through FIFO. A pop on a full FIFO frees the slot before a
// same-cycle push is judged; a push into an empty FIFO is not popped that cycle.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             pop_ok;
  logic             push_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage array holds data only, so it carries no reset.
  always_ff @(posedge clk_in) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers wrap naturally at DEPTH; occupancy tracks pushes minus pops.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mic_frontend.sv
// Microphone conditioning: captures receiver samples across the bit-clock
// boundary, optional DC-blocking high-pass, saturating power-of-two gain,
// and a FIFO toward the vocoder analysis path.
module mic_frontend
  import constants::*;
#(
  parameter int WIDTH    = SYNTH_WIDTH,
  parameter int DC_SHIFT = MIC_DC_SHIFT,
  parameter int DEPTH    = MIC_FIFO_DEPTH
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [WIDTH-1:0]       sample_in,
  input  logic                   valid_in,
  input  logic                   bypass_dc_in,
  input  logic [3:0]             gain_shift_in,
  output logic [WIDTH-1:0]       m_data_out,
  output logic                   m_valid_out,
  input  logic                   m_ready_in,
  output logic                   overflow_out,
  output logic [$clog2(DEPTH):0] count_out
);

  logic vld_meta_q, vld_sync_q, vld_dly_q;
  logic capture;

  mic_fe_state_t state_q, state_d;

  logic signed [WIDTH-1:0]  x_cur_q, x_prev_q, y_prev_q, res_q, gain_q;
  logic signed [WIDTH+1:0]  x_cur_w, x_prev_w, y_prev_w, y_full;
  logic signed [WIDTH-1:0]  y_sat, filt_res;
  logic signed [WIDTH+14:0] g_ext, g_full;
  logic signed [WIDTH-1:0]  g_sat;

  logic push, fifo_empty, fifo_full, overflow_q;

  // valid_in is launched on the receiver bit clock: two flops to resolve
  // metastability, a third to find the rising edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vld_meta_q <= 1'b0;
      vld_sync_q <= 1'b0;
      vld_dly_q  <= 1'b0;
    end else begin
      vld_meta_q <= valid_in;
      vld_sync_q <= vld_meta_q;
      vld_dly_q  <= vld_sync_q;
    end
  end

  assign capture = vld_sync_q & ~vld_dly_q;

  // FSM state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // One cycle per stage; edges seen outside IDLE are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (capture) state_d = S_FILT;
      S_FILT:  state_d = S_GAIN;
      S_GAIN:  state_d = S_PUSH;
      S_PUSH:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // y = x - x_prev + y_prev - y_prev/2^DC_SHIFT with two guard bits.
  assign x_cur_w  = {{2{x_cur_q[WIDTH-1]}}, x_cur_q};
  assign x_prev_w = {{2{x_prev_q[WIDTH-1]}}, x_prev_q};
  assign y_prev_w = {{2{y_prev_q[WIDTH-1]}}, y_prev_q};
  assign y_full   = x_cur_w - x_prev_w + y_prev_w - (y_prev_w >>> DC_SHIFT);
  assign y_sat    = WIDTH'(sat_to_width(64'(y_full), WIDTH));
  assign filt_res = bypass_dc_in ? x_cur_q : y_sat;

  // Gain: up to 15 bits of left shift, then clamp.
  assign g_ext  = {{15{res_q[WIDTH-1]}}, res_q};
  assign g_full = g_ext <<< gain_shift_in;
  assign g_sat  = WIDTH'(sat_to_width(64'(g_full), WIDTH));

  // Pipeline data registers: sample latch, filter result, gain result.
  always_ff @(posedge clk_in) begin
    if (state_q == S_IDLE && capture) x_cur_q <= sample_in;
    if (state_q == S_FILT)            res_q   <= filt_res;
    if (state_q == S_GAIN)            gain_q  <= g_sat;
  end

  // High-pass history; in bypass it tracks the raw input so re-enabling
  // the filter starts from the current signal level.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      x_prev_q <= '0;
      y_prev_q <= '0;
    end else if (state_q == S_FILT) begin
      x_prev_q <= x_cur_q;
      y_prev_q <= filt_res;
    end
  end

  assign push = (state_q == S_PUSH);

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .push_i      (push),
    .push_data_i (gain_q),
    .pop_i       (m_ready_in),
    .head_o      (m_data_out),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (count_out)
  );

  assign m_valid_out = ~fifo_empty;

  // Sticky drop flag: a full FIFO with no same-cycle pop rejects the push.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                                 overflow_q <= 1'b0;
    else if (push && fifo_full && !m_ready_in)  overflow_q <= 1'b1;
  end

  assign overflow_out = overflow_q;

endmodule

// File: doc/mic_frontend.md
# mic_frontend

Conditioning stage directly downstream of the I2S PMOD microphone receiver. It takes each sample/valid pair from the receiver (launched on the receiver's bit clock) into the `clk_in` domain. It optionally removes DC with a first-order high-pass, applies a saturating power-of-two gain, and buffers results in a 16-entry FIFO with a valid/ready output toward the vocoder analysis path.

## Interface
Parameters:
- `WIDTH`, default `constants::SYNTH_WIDTH`: sample width, signed two's complement.
- `DC_SHIFT`, default `constants::MIC_DC_SHIFT` (10): high-pass pole, `a = 1 - 2^-DC_SHIFT`.
- `DEPTH`, default `constants::MIC_FIFO_DEPTH` (16): FIFO entries, power of two.

Ports:
- `clk_in`, in, 1: system clock (98.3 MHz).
- `rst_in`, in, 1: reset, asynchronous, active-high.
- `sample_in`, in, WIDTH: sample from the mic receiver; stable while `valid_in` is high and for at least 30 `clk_in` cycles after its rise.
- `valid_in`, in, 1: receiver valid, one bit-clock period wide (32 `clk_in` cycles). Asynchronous to `clk_in` edges.
- `bypass_dc_in`, in, 1: 1 = skip the high-pass stage.
- `gain_shift_in`, in, 4: left-shift amount, 0–15; sampled at the GAIN state.
- `m_data_out`, out, WIDTH: FIFO head.
- `m_valid_out`, out, 1: FIFO not empty.
- `m_ready_in`, in, 1: consumer accepts the head when `m_valid_out & m_ready_in`.
- `overflow_out`, out, 1: sticky; a sample was dropped because the FIFO was full.
- `count_out`, out, $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Input capture: `valid_in` goes through a 2-flop synchronizer, then a third register for rising-edge detect.
  - One capture per rising edge, however long `valid_in` stays high.
  - On capture, latch `sample_in` into `x_cur`.
- FSM states `S_IDLE → S_FILT → S_GAIN → S_PUSH → S_IDLE`, one cycle each.
  - A capture edge arriving while the FSM is not in IDLE is impossible at the specified rates. If it does occur, it is ignored.
- `S_FILT`:
  - Computes `y = x_cur - x_prev + y_prev - (y_prev >>> DC_SHIFT)` in WIDTH+2 signed bits.
  - Saturates `y` to WIDTH bits (max 0x7F..F, min 0x80..0).
  - Updates `x_prev <= x_cur` and `y_prev <= y_sat`.
  - If `bypass_dc_in`, the result is `x_cur`; `x_prev` and `y_prev` are still updated, with `y_prev <= x_cur`.
- `S_GAIN`:
  - Computes `g = result <<< gain_shift_in` in WIDTH+15 bits.
  - Saturates `g` to WIDTH bits, same bounds as above.
- `S_PUSH`:
  - Writes `g` to the FIFO if not full.
  - If full: drops the sample and sets `overflow_out`.
- FIFO:
  - First-word-fall-through.
  - Simultaneous push and pop when full: the pop frees space first, so the push succeeds.
  - Simultaneous push and pop when empty: the push lands and `m_valid_out` rises the next cycle; nothing pops.
  - Pointers wrap modulo DEPTH. Occupancy is tracked by `count_out` (0..DEPTH).
- Reset (asynchronous, any time):
  - Clears the synchronizer, FSM (to IDLE), `x_prev`, `y_prev`, FIFO pointers and count, and `overflow_out`.
  - A sample in flight is discarded.

## Timing
- Reset values: `m_data_out` 0, `m_valid_out` 0, `overflow_out` 0, `count_out` 0.
- Define E as the `clk_in` edge that captures: the 3rd rising edge at which `valid_in` is seen high.
  - FILT registers at E+1.
  - GAIN registers at E+2.
  - FIFO write at E+3.
  - `m_valid_out` is high after E+3 if the FIFO was empty.
- Throughput: one sample per 2048 `clk_in` cycles (48 kHz). The pipeline is idle more than 99% of the time.
- `overflow_out` sets at the E+3 edge of the dropped sample. It clears only on reset.

## Structure
- Add `MIC_DC_SHIFT = 10` and `MIC_FIFO_DEPTH = 16` to the `constants` package, beside `SYNTH_WIDTH`.
- Add the FSM enum typedef `mic_fe_state_t` to `constants`.
- One sub-module, `sync_fifo`, parameterized by WIDTH and DEPTH:
  - ports: push/data, pop, head, empty, full, count;
  - reset asynchronous, active-high.
- Saturation is a function in the package (`sat_to_width`). It is shared by FILT and GAIN.

## Test plan
All scenarios run with WIDTH=24 and a 32-cycle `valid_in` pulse unless noted.
- Reset: assert `rst_in` mid-pulse. All outputs are 0 within the same cycle. After release, no stale sample appears.
- Bypass, gain 0, `sample_in`=0x123456, `valid_in` held high for 200 cycles: exactly one FIFO entry, 0x123456, with `m_valid_out` high at E+3.
- Saturating gain, bypass on, gain 4:
  - 0x100000 → 0x7FFFFF;
  - 0xF00000 → 0x800000;
  - 0x000123 → 0x001230.
- DC block, DC on, gain 0, constant 0x010000 for 6000 samples:
  - first output 0x010000;
  - outputs are monotonically non-increasing;
  - final output ≤ 0x0003FF.
- FIFO full, `m_ready_in`=0, 17 samples 1..17:
  - `count_out`=16 and `overflow_out`=1 after the 17th;
  - draining yields 1..16 in order, then `m_valid_out`=0.
- Simultaneous push/pop with the FIFO full: `m_ready_in`=1 exactly at the E+3 edge gives `count_out` still 16 and no overflow.
